// File: rtl/dribbler_ctrl_if.sv
// Command handshake between the robot command interface and the dribbler controller.
interface dribbler_ctrl_if #(
  parameter int PWM_BITS = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_run;
  logic                cmd_dir;
  logic [PWM_BITS-1:0] cmd_duty;

  modport master (output cmd_valid, cmd_run, cmd_dir, cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, cmd_run, cmd_dir, cmd_duty, output cmd_ready);
endinterface

// File: rtl/dribbler_ctrl.sv
// Dribbler BLDC sequencer: duty soft-ramp, PWM gating, reversal dead-time, Hall speed.
// Define DRIBBLER_STALL_DETECT_EN to build the stall counter and FAULT latch.
module dribbler_ctrl #(
  parameter int PWM_BITS        = 8,
  parameter int RAMP_DIV        = 256,
  parameter int DEADTIME_CYCLES = 1024,
  parameter int STALL_CYCLES    = 1048576,
  parameter int STALL_MIN_DUTY  = 16,
  parameter int SPEED_WINDOW    = 100000
) (
  input  logic         clk,
  input  logic         rst,
  dribbler_ctrl_if.slave cmd,
  input  logic [2:0]   hall_in,
  output logic [2:0]   hall_out,
  output logic         drv_en,
  output logic         drv_dir,
  output logic [2:0]   state,
  output logic         fault,
  input  logic         fault_clr,
  output logic [15:0]  speed,
  output logic         speed_valid
);
  typedef enum logic [2:0] {IDLE = 3'd0, RAMP = 3'd1, RUN = 3'd2, DEAD = 3'd3, FAULT = 3'd4} state_t;

  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int DW = $clog2(DEADTIME_CYCLES + 1);
  localparam int WW = $clog2(SPEED_WINDOW + 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME_CYCLES);
  localparam logic [WW-1:0] WIN_LAST  = WW'(SPEED_WINDOW - 1);

  state_t st, st_n;
  logic [PWM_BITS-1:0] cur_duty, cur_duty_n, tgt_duty, pwm_cnt, duty_step;
  logic [PWM_BITS-1:0] nxt_duty, eff_nxt;
  logic                tgt_run, tgt_dir, nxt_run;
  logic [RW-1:0]       ramp_cnt;
  logic [DW-1:0]       dead_cnt;
  logic [2:0]          hall_s1, hall_prev;
  logic                hall_edge, accept, reverse, ramp_tick, stall_trip, act, act_n;

  assign state = st;

  // Hall synchronizer; hall_prev gives a one-clock-late copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_s1   <= '0;
      hall_out  <= '0;
      hall_prev <= '0;
    end else begin
      hall_s1   <= hall_in;
      hall_out  <= hall_s1;
      hall_prev <= hall_out;
    end
  end
  assign hall_edge = hall_out != hall_prev;

  assign cmd.cmd_ready = st inside {IDLE, RAMP, RUN};
  // A stall trip wins over a command offered in the same cycle.
  assign accept    = cmd.cmd_valid & cmd.cmd_ready & ~stall_trip;
  assign nxt_run   = accept ? cmd.cmd_run  : tgt_run;
  assign nxt_duty  = accept ? cmd.cmd_duty : tgt_duty;
  assign eff_nxt   = nxt_run ? nxt_duty : '0;
  assign reverse   = accept & cmd.cmd_run & (cmd.cmd_dir != drv_dir);
  assign ramp_tick = ramp_cnt == RAMP_LAST;
  assign duty_step = (eff_nxt > cur_duty) ? cur_duty + 1'b1 : cur_duty - 1'b1;

  always_comb begin
    st_n       = st;
    cur_duty_n = cur_duty;
    case (st)
      IDLE: begin
        cur_duty_n = '0;
        if (accept && cmd.cmd_run && cmd.cmd_duty != '0) st_n = RAMP;
      end
      RAMP: begin
        if (stall_trip) begin
          st_n       = FAULT;
          cur_duty_n = '0;
        end else if (reverse) begin
          st_n       = DEAD;
          cur_duty_n = '0;
        end else if (cur_duty == eff_nxt) begin
          st_n = (eff_nxt != '0) ? RUN : IDLE;
        end else if (ramp_tick) begin
          cur_duty_n = duty_step;
          if (duty_step == eff_nxt) st_n = (eff_nxt != '0) ? RUN : IDLE;
        end
      end
      RUN: begin
        if (stall_trip) begin
          st_n       = FAULT;
          cur_duty_n = '0;
        end else if (reverse) begin
          st_n       = DEAD;
          cur_duty_n = '0;
        end else if (eff_nxt != cur_duty) begin
          st_n = RAMP;
        end
      end
      DEAD: begin
        cur_duty_n = '0;
        if (dead_cnt <= DW'(1)) st_n = (tgt_run && tgt_duty != '0) ? RAMP : IDLE;
      end
      FAULT: begin
        cur_duty_n = '0;
        if (fault_clr) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  assign act   = (st == RAMP) || (st == RUN);
  assign act_n = (st_n == RAMP) || (st_n == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      cur_duty <= '0;
      tgt_run  <= 1'b0;
      tgt_dir  <= 1'b1;
      tgt_duty <= '0;
      drv_dir  <= 1'b1;
      ramp_cnt <= '0;
      dead_cnt <= '0;
      pwm_cnt  <= '0;
      drv_en   <= 1'b0;
    end else begin
      st       <= st_n;
      cur_duty <= cur_duty_n;
      pwm_cnt  <= pwm_cnt + 1'b1;
      if (st_n == FAULT) begin
        tgt_run  <= 1'b0;
        tgt_duty <= '0;
      end else if (accept) begin
        tgt_run  <= cmd.cmd_run;
        tgt_dir  <= cmd.cmd_dir;
        tgt_duty <= cmd.cmd_duty;
      end
      if (st == IDLE && st_n == RAMP)      drv_dir <= cmd.cmd_dir;
      else if (st == DEAD && st_n != DEAD) drv_dir <= tgt_dir;
      // Cleared outside RAMP, so every RAMP entry starts a fresh tick period.
      ramp_cnt <= (st == RAMP && !ramp_tick) ? ramp_cnt + 1'b1 : '0;
      if (st_n == DEAD) dead_cnt <= (st == DEAD) ? dead_cnt - 1'b1 : DEAD_LOAD;
      else              dead_cnt <= '0;
      // Gating on the next state too keeps the first DEAD/FAULT cycle dark.
      drv_en <= act && act_n && (pwm_cnt < cur_duty);
    end
  end

`ifdef DRIBBLER_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);
  logic [SW-1:0] stall_cnt;
  logic          stall_active;

  assign stall_active = act && (cur_duty >= PWM_BITS'(STALL_MIN_DUTY));
  assign stall_trip   = stall_active && !hall_edge && (stall_cnt == STALL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fault     <= 1'b0;
    end else begin
      stall_cnt <= (stall_active && !hall_edge && !stall_trip) ? stall_cnt + 1'b1 : '0;
      fault     <= st_n == FAULT;
    end
  end
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = (STALL_CYCLES == 0) | (STALL_MIN_DUTY == 0);
  assign stall_trip = 1'b0;
  assign fault      = 1'b0;
`endif

  // Speed window; an edge on the closing cycle belongs to the next window.
  logic [WW-1:0] win_cnt;
  logic [15:0]   edge_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      edge_cnt    <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      if (win_cnt == WIN_LAST) begin
        win_cnt     <= '0;
        speed       <= edge_cnt;
        speed_valid <= 1'b1;
        edge_cnt    <= {15'd0, hall_edge};
      end else begin
        win_cnt <= win_cnt + 1'b1;
        if (hall_edge && edge_cnt != 16'hFFFF) edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end
endmodule
